// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter slice: word type, reset and
// alignment constants, and the next-PC source selector.
package pc_gen_pkg;

    localparam int XLEN_DEFAULT      = 32;
    localparam int RAS_DEPTH_DEFAULT = 4;

    typedef logic [XLEN_DEFAULT-1:0] word_t;

    localparam word_t BOOT_ADDRESS_DEFAULT = 32'h0000_0000;

    localparam int IALIGN_32 = 32;
    localparam int IALIGN_16 = 16;

    // Source of the next PC, listed from lowest to highest priority.
    typedef enum logic [1:0] {
        PC_SEQ,
        PC_JUMP,
        PC_JALR,
        PC_TRAP
    } pc_sel_e;

    // Sequential step in bytes for a given instruction alignment in bits.
    function automatic int step_bytes(input int ialign);
        return ialign / 8;
    endfunction

    // Priority encode the redirect requests: trap > jalr > jump > sequential.
    function automatic pc_sel_e select_pc(input logic trap, input logic jalr, input logic jump);
        if (trap)      return PC_TRAP;
        else if (jalr) return PC_JALR;
        else if (jump) return PC_JUMP;
        else           return PC_SEQ;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Execute-stage to PC-generator bundle: redirect requests in, PC state and
// return prediction out.
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) ();

    logic            advance;
    logic            jump;
    logic            jalr;
    logic            trap;
    logic [XLEN-1:0] offset;
    logic [XLEN-1:0] trap_vector;
    logic            is_call;
    logic            is_return;

    logic [XLEN-1:0] instruction_addr;
    logic [XLEN-1:0] ia_plus_step;
    logic            misaligned;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;

    // Execute stage side.
    modport master (
        output advance, jump, jalr, trap, offset, trap_vector, is_call, is_return,
        input  instruction_addr, ia_plus_step, misaligned, ras_top, ras_empty
    );

    // PC generator side.
    modport slave (
        input  advance, jump, jalr, trap, offset, trap_vector, is_call, is_return,
        output instruction_addr, ia_plus_step, misaligned, ras_top, ras_empty
    );

endinterface

// File: rtl/pc_gen_return_stack.sv
// Circular return-address stack. Push overwrites the oldest entry when full,
// pop on empty is ignored, push+pop replaces the top, flush only drops the
// count so stale entries stay behind.
module return_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] entries [DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [CW-1:0]   count_q;

    logic          do_push;
    logic          do_swap;
    logic          do_pop;
    logic          wr_en;
    logic [PW-1:0] wr_idx;

    // Decode the requested operation against the current occupancy.
    // NOTE: every signal gets a value on every path so no latch is inferred.
    always_comb begin
        do_push = 1'b0;
        do_swap = 1'b0;
        do_pop  = 1'b0;
        if (!reset && !flush) begin
            do_push = push && (!pop || count_q == '0);
            do_swap = push && pop && count_q != '0;
            do_pop  = pop && !push && count_q != '0;
        end
        wr_en  = do_push || do_swap;
        wr_idx = do_swap ? ptr_q : ptr_q + 1'b1;
    end

    // Pointer and occupancy count.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else if (do_push) begin
            ptr_q <= ptr_q + 1'b1;
            if (count_q != CW'(DEPTH)) count_q <= count_q + 1'b1;
        end else if (do_pop) begin
            ptr_q   <= ptr_q - 1'b1;
            count_q <= count_q - 1'b1;
        end
    end

    // Entry storage.
    // NOTE: the array is deliberately not reset; count gates every read, so it can map to plain RAM.
    always_ff @(posedge clock) begin
        if (wr_en) entries[wr_idx] <= push_data;
    end

    assign top   = (count_q != '0) ? entries[ptr_q] : '0;
    assign empty = (count_q == '0);

endmodule

// File: rtl/pc_gen.sv
// Program counter for the fetch/execute boundary: next-PC selection, target
// alignment check, registered link address and return-address prediction.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] BOOT_ADDRESS = XLEN'(BOOT_ADDRESS_DEFAULT),
    parameter int              IALIGN       = IALIGN_32,
    parameter int              RAS_DEPTH    = RAS_DEPTH_DEFAULT
) (
    input logic     clock,
    input logic     reset,
    pc_gen_if.slave bus
);

    localparam logic [XLEN-1:0] STEP = XLEN'(step_bytes(IALIGN));

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] link_q;
    logic            misaligned_q;

    pc_sel_e         sel;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] next_pc;
    logic            is_redirect;
    logic            target_bad;
    logic            accept;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_flush;

    // Next-PC mux, alignment check and RAS operation decode.
    always_comb begin
        sel     = select_pc(bus.trap, bus.jalr, bus.jump);
        seq_pc  = pc_q + STEP;
        next_pc = seq_pc;
        case (sel)
            PC_TRAP: next_pc = bus.trap_vector;
            PC_JALR: next_pc = {bus.offset[XLEN-1:1], 1'b0};
            PC_JUMP: next_pc = pc_q + bus.offset;
            default: next_pc = seq_pc;
        endcase
        is_redirect = (sel == PC_JUMP) || (sel == PC_JALR);
        // 16-bit alignment is always met since jalr clears bit 0 and jump offsets are even.
        target_bad  = is_redirect && (IALIGN == IALIGN_32) && next_pc[1];
        accept      = bus.advance && !target_bad;
        ras_push    = accept && is_redirect && bus.is_call;
        ras_pop     = accept && (sel == PC_JALR) && bus.is_return;
        ras_flush   = accept && (sel == PC_TRAP);
    end

    // PC, link address and one-cycle fault pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= BOOT_ADDRESS;
            link_q       <= BOOT_ADDRESS + STEP;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= bus.advance && target_bad;
            if (accept) begin
                pc_q   <= next_pc;
                link_q <= seq_pc;
            end
        end
    end

    return_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .flush     (ras_flush),
        .push_data (seq_pc),
        .top       (bus.ras_top),
        .empty     (bus.ras_empty)
    );

    assign bus.instruction_addr = pc_q;
    assign bus.ia_plus_step     = link_q;
    assign bus.misaligned       = misaligned_q;

    // Trap targets are never subject to the alignment check.
    assert property (@(posedge clock) disable iff (reset) (sel == PC_TRAP) |-> !target_bad);

    // A rejected target leaves the PC where it was.
    assert property (@(posedge clock) disable iff (reset)
                     (bus.advance && target_bad) |=> (pc_q == $past(pc_q)));

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam logic [31:0] BOOT = 32'h0000_0000;
    localparam int          DEPTH = 4;

    logic clock = 1'b0;
    logic reset;
    logic reset16;

    always #5 clock = ~clock;

    pc_gen_if #(.XLEN(32)) bus   ();
    pc_gen_if #(.XLEN(32)) bus16 ();

    pc_gen #(.XLEN(32), .BOOT_ADDRESS(BOOT), .IALIGN(32), .RAS_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    pc_gen #(.XLEN(32), .BOOT_ADDRESS(BOOT), .IALIGN(16), .RAS_DEPTH(DEPTH)) dut16 (
        .clock (clock),
        .reset (reset16),
        .bus   (bus16)
    );

    // Reference model state for the IALIGN=32 instance; ras back() is the top.
    logic [31:0] m_pc;
    logic [31:0] m_link;
    logic        m_mis;
    logic [31:0] m_ras[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] model_top();
        return (m_ras.size() != 0) ? m_ras[$] : 32'h0;
    endfunction

    // Architectural behaviour of one clock edge, written from the rules.
    task automatic model_update(input logic rst, input logic adv, input logic jmp, input logic jr,
                                input logic trp, input logic [31:0] off, input logic [31:0] vec,
                                input logic call, input logic ret);
        logic [31:0] target;
        logic [31:0] link;
        if (rst) begin
            m_pc   = BOOT;
            m_link = BOOT + 32'd4;
            m_mis  = 1'b0;
            m_ras.delete();
            return;
        end
        m_mis = 1'b0;
        if (!adv) return;
        link = m_pc + 32'd4;
        if (trp) begin
            m_pc   = vec;
            m_link = link;
            m_ras.delete();
        end else if (jr || jmp) begin
            target = jr ? (off & ~32'h1) : m_pc + off;
            if (target[1]) begin
                m_mis = 1'b1;
            end else begin
                if (call && jr && ret) begin
                    if (m_ras.size() == 0) m_ras.push_back(link);
                    else m_ras[m_ras.size() - 1] = link;
                end else if (call) begin
                    m_ras.push_back(link);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end else if (jr && ret && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
                m_pc   = target;
                m_link = link;
            end
        end else begin
            m_pc   = link;
            m_link = link;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pc"},         bus.instruction_addr, m_pc);
        check({tag, ".link"},       bus.ia_plus_step,     m_link);
        check({tag, ".misaligned"}, 32'(bus.misaligned),  32'(m_mis));
        check({tag, ".ras_top"},    bus.ras_top,          model_top());
        check({tag, ".ras_empty"},  32'(bus.ras_empty),   32'(m_ras.size() == 0));
    endtask

    // Drive one cycle of stimulus to both instances, clock it, then compare.
    task automatic step(input string tag, input logic rst, input logic adv, input logic jmp,
                        input logic jr, input logic trp, input logic [31:0] off,
                        input logic [31:0] vec, input logic call, input logic ret);
        reset             = rst;
        bus.advance       = adv;   bus16.advance     = adv;
        bus.jump          = jmp;   bus16.jump        = jmp;
        bus.jalr          = jr;    bus16.jalr        = jr;
        bus.trap          = trp;   bus16.trap        = trp;
        bus.offset        = off;   bus16.offset      = off;
        bus.trap_vector   = vec;   bus16.trap_vector = vec;
        bus.is_call       = call;  bus16.is_call     = call;
        bus.is_return     = ret;   bus16.is_return   = ret;
        @(posedge clock);
        model_update(rst, adv, jmp, jr, trp, off, vec, call, ret);
        #1;
        check_state(tag);
    endtask

    task automatic seq_adv(input string tag);
        step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_jump(input string tag, input logic [31:0] off, input logic call);
        step(tag, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, off, 32'h0, call, 1'b0);
    endtask

    task automatic do_jalr(input string tag, input logic [31:0] off, input logic call, input logic ret);
        step(tag, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, off, 32'h0, call, ret);
    endtask

    initial begin
        logic        r_rst, r_adv, r_jmp, r_jr, r_trp, r_call, r_ret;
        logic [31:0] r_off, r_vec;
        int          kind;

        reset16 = 1'b1;

        // Reset state, then three sequential advances.
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("reset.pc_const",    bus.instruction_addr, 32'h0);
        check("reset.link_const",  bus.ia_plus_step,     32'h4);
        check("reset.empty_const", 32'(bus.ras_empty),   32'h1);
        check("reset.top_const",   bus.ras_top,          32'h0);
        for (int i = 1; i <= 3; i++) begin
            seq_adv("seq");
            check("seq.pc_const",   bus.instruction_addr, 32'(4 * i));
            check("seq.link_const", bus.ia_plus_step,     32'(4 * i));
        end

        // Relative jump backwards, jalr bit-0 clear, and hold with advance low.
        do_jump("to_100", 32'h0000_00F4, 1'b0);
        check("to_100.pc_const", bus.instruction_addr, 32'h100);
        do_jump("back_8", 32'hFFFF_FFF8, 1'b0);
        check("back_8.pc_const", bus.instruction_addr, 32'h0F8);
        do_jalr("jalr_2001", 32'h2001, 1'b0, 1'b0);
        check("jalr_2001.pc_const", bus.instruction_addr, 32'h2000);
        step("hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
        check("hold.pc_const", bus.instruction_addr, 32'h2000);

        // Misaligned jump target is rejected for one cycle, call ignored.
        do_jalr("to_40", 32'h40, 1'b0, 1'b0);
        do_jump("misalign", 32'h6, 1'b1);
        check("misalign.flag_const",  32'(bus.misaligned), 32'h1);
        check("misalign.pc_const",    bus.instruction_addr, 32'h40);
        check("misalign.empty_const", 32'(bus.ras_empty), 32'h1);
        step("after_mis", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("after_mis.flag_const", 32'(bus.misaligned), 32'h0);

        // Five calls into a four-deep stack, then returns down to empty.
        do_jalr("to_10", 32'h10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) do_jump("call", 32'h10, 1'b1);
        check("calls.top_const", bus.ras_top, 32'h54);
        for (int i = 0; i < 4; i++) begin
            check("ret.top_const", bus.ras_top, 32'h54 - 32'(16 * i));
            do_jalr("ret", 32'h54 - 32'(16 * i), 1'b0, 1'b1);
        end
        check("ret.empty_const", 32'(bus.ras_empty), 32'h1);
        do_jalr("ret_empty", 32'h100, 1'b0, 1'b1);
        check("ret_empty.empty_const", 32'(bus.ras_empty), 32'h1);

        // Coroutine swap keeps one entry, then trap flushes.
        do_jalr("to_10b", 32'h10, 1'b0, 1'b0);
        do_jump("call_80", 32'h70, 1'b1);
        do_jalr("swap", 32'h200, 1'b1, 1'b1);
        check("swap.top_const",   bus.ras_top, 32'h84);
        check("swap.empty_const", 32'(bus.ras_empty), 32'h0);
        do_jalr("swap_pop", 32'h84, 1'b0, 1'b1);
        check("swap_pop.empty_const", 32'(bus.ras_empty), 32'h1);
        do_jump("call_again", 32'h10, 1'b1);
        step("trap", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h800, 1'b0, 1'b0);
        check("trap.pc_const",    bus.instruction_addr, 32'h800);
        check("trap.empty_const", 32'(bus.ras_empty), 32'h1);

        // Reset overrides a simultaneous advance and trap.
        do_jalr("to_100b", 32'h100, 1'b0, 1'b0);
        do_jump("call_180", 32'h80, 1'b1);
        do_jump("call_200", 32'h80, 1'b1);
        check("pre_reset.pc_const",  bus.instruction_addr, 32'h200);
        check("pre_reset.top_const", bus.ras_top, 32'h184);
        step("mid_reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h6, 32'h800, 1'b1, 1'b0);
        check("mid_reset.pc_const",    bus.instruction_addr, BOOT);
        check("mid_reset.empty_const", 32'(bus.ras_empty), 32'h1);
        check("mid_reset.mis_const",   32'(bus.misaligned), 32'h0);
        check("ia16.reset_pc",   bus16.instruction_addr, 32'h0);
        check("ia16.reset_link", bus16.ia_plus_step,     32'h2);

        // Same offset-6 jump on the 16-bit aligned instance is accepted.
        reset16 = 1'b0;
        do_jump("j40", 32'h40, 1'b0);
        check("ia16.j40_pc", bus16.instruction_addr, 32'h40);
        do_jump("j6", 32'h6, 1'b0);
        check("ia16.j6_pc",   bus16.instruction_addr, 32'h46);
        check("ia16.j6_link", bus16.ia_plus_step,     32'h42);
        check("ia16.j6_mis",  32'(bus16.misaligned),  32'h0);
        seq_adv("seq16");
        check("ia16.seq_pc",   bus16.instruction_addr, 32'h48);
        check("ia16.seq_link", bus16.ia_plus_step,     32'h48);
        reset16 = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            kind   = int'($urandom_range(0, 9));
            r_rst  = ($urandom_range(0, 99) < 2);
            r_adv  = ($urandom_range(0, 3) != 0);
            r_trp  = (kind == 0);
            r_jr   = (kind == 1 || kind == 2) || ($urandom_range(0, 7) == 0);
            r_jmp  = (kind == 3 || kind == 4) || ($urandom_range(0, 7) == 0);
            r_call = ($urandom_range(0, 1) == 1);
            r_ret  = ($urandom_range(0, 4) < 2);
            r_off  = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 3) == 0) r_off[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0) r_off = -r_off;
            if (r_jr && r_ret && $urandom_range(0, 1) == 1) r_off = model_top();
            r_vec  = $urandom & 32'hFFFF_FFFC;
            step("rand", r_rst, r_adv, r_jmp, r_jr, r_trp, r_off, r_vec, r_call, r_ret);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised next-generation program counter for the fetch/execute boundary of the 7-stage core. It holds the instruction address and a registered link address (PC + step). It selects the next PC, in priority order, from trap vector, jalr target, pc-relative jump or sequential step. It adds instruction-alignment fault detection and a small circular return-address stack (RAS) that publishes a predicted return target to the front end.

Parameters:
XLEN, 32, width of all addresses and offsets
BOOT_ADDRESS, 32'h0000_0000, PC value loaded on reset
IALIGN, 32, instruction alignment in bits (32 or 16); step = IALIGN/8
RAS_DEPTH, 4, RAS entries (power of two, >= 2)

Ports:
clock  in  1  system clock
reset  in  1  reset, synchronous, active-high
advance  in  1  PC update enable (one pulse per retired execute stage)
jump  in  1  pc-relative redirect (jal / taken branch)
jalr  in  1  register-indirect redirect
trap  in  1  exception/interrupt redirect
offset  in  XLEN  jump offset (jump) or absolute target (jalr)
trap_vector  in  XLEN  trap handler address
is_call  in  1  current jump/jalr writes a link register (x1/x5)
is_return  in  1  current jalr is a return (rs1 = x1/x5)
instruction_addr  out  XLEN  current PC
ia_plus_step  out  XLEN  registered link address (old PC + step)
misaligned  out  1  one-cycle pulse: rejected target was misaligned
ras_top  out  XLEN  predicted return address (top of RAS)
ras_empty  out  1  RAS holds no valid entry

Behaviour:
- Reset (synchronous, priority over everything):
  - instruction_addr = BOOT_ADDRESS; ia_plus_step = BOOT_ADDRESS + step; misaligned = 0.
  - RAS count = 0, pointer = 0, ras_empty = 1, ras_top = 0.
- Registers change only on a clock edge with advance = 1, except that misaligned clears to 0 on every edge where it is not being set.
- Next-PC mux (combinational), priority trap > jalr > jump > sequential:
  - trap: trap_vector.
  - jalr: offset with bit 0 cleared.
  - jump: instruction_addr + offset, modulo 2^XLEN.
  - else: instruction_addr + step.
- Alignment check on jump/jalr targets only: misaligned if target[1] = 1 when IALIGN = 32; never for IALIGN = 16 (bit 0 already 0 or cleared).
  - On a misaligned target with advance: PC, ia_plus_step and RAS are held; misaligned = 1 for exactly one cycle.
  - Trap targets are never checked.
- Accepted advance: ia_plus_step <= instruction_addr + step (old PC); instruction_addr <= next PC. Latency is one cycle, with no bubble.
- RAS, updated only on an accepted jump/jalr (not trap, not misaligned):
  - push (is_call, no pop): write old PC + step at pointer+1, then advance pointer. count = min(count+1, RAS_DEPTH); when full, the oldest entry is overwritten (pointer wraps).
  - pop (jalr & is_return, no push): pointer-1 (wraps), count-1; pop on empty is ignored and count stays 0.
  - push and pop together (jalr & is_call & is_return, coroutine swap): top entry is replaced by the new link; pointer and count unchanged; if count = 0 this acts as a push.
  - is_call/is_return with neither jump nor jalr: ignored.
- Trap with advance: RAS flushed (count = 0); entries are left stale.
- ras_top = entry[pointer] whenever count > 0, else 0; ras_empty = (count == 0). Both combinational from registers.
- advance = 0: all redirects and RAS ops are ignored; outputs are stable.
- Reset asserted mid-sequence overrides any same-cycle advance/trap.

Decomposition:
- Shared package (common definitions): XLEN-based word type, BOOT_ADDRESS default, IALIGN constants, and a pc_sel enum (PC_SEQ, PC_JUMP, PC_JALR, PC_TRAP) used by the mux and by assertions.
- One natural sub-module: return_stack (circular LIFO with push/pop/swap/flush, count saturation, top read port), parametrised by XLEN and RAS_DEPTH.
- The PC register, next-PC mux and alignment check stay in pc_gen.

Test Plan:
- Reset then 3 advances, defaults -> instruction_addr 0x0, 0x4, 0x8, 0xC; ia_plus_step 0x4 after reset, then 0x4, 0x8, 0xC after each advance.
- PC = 0x100; jump offset 0xFFFF_FFF8 -> 0x0F8; jalr offset 0x2001 -> 0x2000; advance = 0 with jump held -> PC unchanged.
- PC = 0x40, jump offset 0x6 (IALIGN 32) -> misaligned pulses 1 cycle; PC stays 0x40; RAS unchanged. Same stimulus with IALIGN 16 -> PC 0x46, no fault.
- Five calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 (depth 4) -> ras_top 0x54; four returns pop 0x54, 0x44, 0x34, 0x24, then ras_empty = 1; a fifth return is ignored.
- Call from 0x10 followed by jalr with is_call & is_return at 0x80 -> ras_top 0x84, count still 1. Then trap with vector 0x800 and jump asserted -> PC 0x800, ras_empty = 1.
- Assert reset together with advance and trap while PC = 0x200 and RAS holds 2 entries -> PC = BOOT_ADDRESS, ras_empty = 1, misaligned = 0.
